control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 74 +++++++
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_sequencer_op_decoder.sv | 54 +++++
 rtl/control_sequencer.sv | 162 ++++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: state register, opcodes, ALU codes,
// and the decoder classification and strobe bundles.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    typedef logic [4:0] opcode_t;
    typedef logic [3:0] alu_ctrl_t;

    localparam opcode_t OP_ADD  = 5'b00000;
    localparam opcode_t OP_SUB  = 5'b00001;
    localparam opcode_t OP_AND  = 5'b00010;
    localparam opcode_t OP_OR   = 5'b00011;
    localparam opcode_t OP_SHR  = 5'b00100;
    localparam opcode_t OP_SHL  = 5'b00101;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    localparam alu_ctrl_t ALU_NONE = 4'b0000;
    localparam alu_ctrl_t ALU_ADD  = 4'b0001;
    localparam alu_ctrl_t ALU_SUB  = 4'b0010;
    localparam alu_ctrl_t ALU_AND  = 4'b0011;
    localparam alu_ctrl_t ALU_OR   = 4'b0100;
    localparam alu_ctrl_t ALU_SHR  = 4'b0101;
    localparam alu_ctrl_t ALU_SHL  = 4'b0110;
    localparam alu_ctrl_t ALU_MUL  = 4'b0111;
    localparam alu_ctrl_t ALU_DIV  = 4'b1000;

    typedef struct packed {
        alu_ctrl_t alu_ctrl;
        logic      is_alu;
        logic      is_muldiv;
        logic      is_nop;
        logic      is_halt;
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlo_out;
        logic zhi_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } strobes_t;

    function automatic opcode_t opcode_of(input logic [31:0] ir);
        return ir[31:27];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer (master) and the datapath (slave):
// instruction/handshake inputs plus every load/drive strobe.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [31:0] IR;
    logic        Strt;
    logic        Stop;

    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Zin;
    logic        Zloout;
    logic        Zhiout;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        HIin;
    logic        LOin;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;

    alu_ctrl_t   ALUControl;
    logic        Run;

    modport master (
        input  IR, Strt, Stop,
        output PCout, MARin, IncPC, Zin, Zloout, Zhiout, PCin, Read,
               MDRin, MDRout, IRin, Yin, HIin, LOin,
               Gra, Grb, Grc, Rin, Rout, ALUControl, Run
    );

    modport slave (
        output IR, Strt, Stop,
        input  PCout, MARin, IncPC, Zin, Zloout, Zhiout, PCin, Read,
               MDRin, MDRout, IRin, Yin, HIin, LOin,
               Gra, Grb, Grc, Rin, Rout, ALUControl, Run
    );

endinterface

// File: rtl/control_sequencer_op_decoder.sv
// Opcode classifier: ALU operation code plus alu / muldiv / nop / halt class.
// Any opcode not listed is treated as a NOP so it never writes a register.
module op_decoder
    import control_sequencer_pkg::*;
(
    input  opcode_t   opcode,
    output op_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD: begin
                cls.alu_ctrl = ALU_ADD;
                cls.is_alu   = 1'b1;
            end
            OP_SUB: begin
                cls.alu_ctrl = ALU_SUB;
                cls.is_alu   = 1'b1;
            end
            OP_AND: begin
                cls.alu_ctrl = ALU_AND;
                cls.is_alu   = 1'b1;
            end
            OP_OR: begin
                cls.alu_ctrl = ALU_OR;
                cls.is_alu   = 1'b1;
            end
            OP_SHR: begin
                cls.alu_ctrl = ALU_SHR;
                cls.is_alu   = 1'b1;
            end
            OP_SHL: begin
                cls.alu_ctrl = ALU_SHL;
                cls.is_alu   = 1'b1;
            end
            OP_MUL: begin
                cls.alu_ctrl  = ALU_MUL;
                cls.is_muldiv = 1'b1;
            end
            OP_DIV: begin
                cls.alu_ctrl  = ALU_DIV;
                cls.is_muldiv = 1'b1;
            end
            OP_HALT: begin
                cls.is_halt = 1'b1;
            end
            default: begin
                cls.is_nop = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: T0-T6 fetch/execute timing with HALT, Strt resume
// and a sticky stop request honoured at the end of the current instruction.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                Clock,
    input  logic                GlobalReset,
    control_sequencer_if.master bus
);

    state_t    state;
    state_t    next_state;
    logic      active;
    logic      stop_pending;
    op_class_t op;
    strobes_t  strb;
    alu_ctrl_t alu_control;
    logic      run;
    logic      executes;
    logic      unused_ir_bits;

    assign unused_ir_bits = ^bus.IR[26:0];

    op_decoder u_op_decoder (
        .opcode (opcode_of(bus.IR)),
        .cls    (op)
    );

    assign executes = op.is_alu | op.is_muldiv;

    // 'active' holds strobes low until the first edge after reset, which executes T0.
    always_ff @(posedge Clock or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state        <= ST_T0;
            active       <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            state  <= next_state;
            active <= 1'b1;
            if ((next_state == ST_HALT) && (state != ST_HALT)) begin
                stop_pending <= 1'b0;
            end else if (bus.Stop) begin
                stop_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = ST_T0;
        case (state)
            ST_T0: next_state = ST_T1;
            ST_T1: next_state = ST_T2;
            ST_T2: next_state = ST_T3;
            ST_T3: begin
                if (op.is_halt) begin
                    next_state = ST_HALT;
                end else if (executes) begin
                    next_state = ST_T4;
                end else begin
                    next_state = ST_T0;
                end
            end
            ST_T4: next_state = ST_T5;
            ST_T5: begin
                if (op.is_muldiv) begin
                    next_state = ST_T6;
                end else if (stop_pending) begin
                    next_state = ST_HALT;
                end else begin
                    next_state = ST_T0;
                end
            end
            ST_T6:   next_state = stop_pending ? ST_HALT : ST_T0;
            ST_HALT: next_state = bus.Strt ? ST_T0 : ST_HALT;
            default: next_state = ST_T0;
        endcase
        if (!active) begin
            next_state = ST_T0;
        end
    end

    // Output decode depends only on registered state and the datapath's IR register.
    always_comb begin
        strb        = '0;
        alu_control = ALU_NONE;
        run         = (state != ST_HALT);
        if (active) begin
            case (state)
                ST_T0: begin
                    strb.pc_out = 1'b1;
                    strb.mar_in = 1'b1;
                    strb.inc_pc = 1'b1;
                    strb.z_in   = 1'b1;
                end
                ST_T1: begin
                    strb.zlo_out = 1'b1;
                    strb.pc_in   = 1'b1;
                    strb.read    = 1'b1;
                    strb.mdr_in  = 1'b1;
                end
                ST_T2: begin
                    strb.mdr_out = 1'b1;
                    strb.ir_in   = 1'b1;
                end
                ST_T3: begin
                    if (executes) begin
                        strb.grb   = 1'b1;
                        strb.r_out = 1'b1;
                        strb.y_in  = 1'b1;
                    end
                end
                ST_T4: begin
                    if (executes) begin
                        strb.grc    = 1'b1;
                        strb.r_out  = 1'b1;
                        strb.z_in   = 1'b1;
                        alu_control = op.alu_ctrl;
                    end
                end
                ST_T5: begin
                    if (op.is_alu) begin
                        strb.zlo_out = 1'b1;
                        strb.gra     = 1'b1;
                        strb.r_in    = 1'b1;
                    end else if (op.is_muldiv) begin
                        strb.zlo_out = 1'b1;
                        strb.lo_in   = 1'b1;
                    end
                end
                ST_T6: begin
                    strb.zhi_out = 1'b1;
                    strb.hi_in   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.PCout      = strb.pc_out;
    assign bus.MARin      = strb.mar_in;
    assign bus.IncPC      = strb.inc_pc;
    assign bus.Zin        = strb.z_in;
    assign bus.Zloout     = strb.zlo_out;
    assign bus.Zhiout     = strb.zhi_out;
    assign bus.PCin       = strb.pc_in;
    assign bus.Read       = strb.read;
    assign bus.MDRin      = strb.mdr_in;
    assign bus.MDRout     = strb.mdr_out;
    assign bus.IRin       = strb.ir_in;
    assign bus.Yin        = strb.y_in;
    assign bus.HIin       = strb.hi_in;
    assign bus.LOin       = strb.lo_in;
    assign bus.Gra        = strb.gra;
    assign bus.Grb        = strb.grb;
    assign bus.Grc        = strb.grc;
    assign bus.Rin        = strb.r_in;
    assign bus.Rout       = strb.r_out;
    assign bus.ALUControl = alu_control;
    assign bus.Run        = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-cycle vector table for every
// instruction class plus hand-written reset corner cases.
module tb_control_sequencer;

    logic Clock;
    logic GlobalReset;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock       (Clock),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe bit positions in {PCout .. Rout} order
    localparam logic [18:0] M_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] M_MARIN  = 19'd1 << 17;
    localparam logic [18:0] M_INCPC  = 19'd1 << 16;
    localparam logic [18:0] M_ZIN    = 19'd1 << 15;
    localparam logic [18:0] M_ZLOOUT = 19'd1 << 14;
    localparam logic [18:0] M_ZHIOUT = 19'd1 << 13;
    localparam logic [18:0] M_PCIN   = 19'd1 << 12;
    localparam logic [18:0] M_READ   = 19'd1 << 11;
    localparam logic [18:0] M_MDRIN  = 19'd1 << 10;
    localparam logic [18:0] M_MDROUT = 19'd1 << 9;
    localparam logic [18:0] M_IRIN   = 19'd1 << 8;
    localparam logic [18:0] M_YIN    = 19'd1 << 7;
    localparam logic [18:0] M_HIIN   = 19'd1 << 6;
    localparam logic [18:0] M_LOIN   = 19'd1 << 5;
    localparam logic [18:0] M_GRA    = 19'd1 << 4;
    localparam logic [18:0] M_GRB    = 19'd1 << 3;
    localparam logic [18:0] M_GRC    = 19'd1 << 2;
    localparam logic [18:0] M_RIN    = 19'd1 << 1;
    localparam logic [18:0] M_ROUT   = 19'd1 << 0;

    localparam logic [18:0] E_NONE = 19'd0;
    localparam logic [18:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [18:0] E_T1   = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [18:0] E_T2   = M_MDROUT | M_IRIN;
    localparam logic [18:0] E_T3   = M_GRB | M_ROUT | M_YIN;
    localparam logic [18:0] E_T4   = M_GRC | M_ROUT | M_ZIN;
    localparam logic [18:0] E_T5A  = M_ZLOOUT | M_GRA | M_RIN;
    localparam logic [18:0] E_T5M  = M_ZLOOUT | M_LOIN;
    localparam logic [18:0] E_T6   = M_ZHIOUT | M_HIIN;

    localparam logic [31:0] IR_ADD  = 32'h0000_0000;
    localparam logic [31:0] IR_SUB  = 32'h0800_0000;
    localparam logic [31:0] IR_AND  = 32'h1000_0000;
    localparam logic [31:0] IR_OR   = 32'h1800_0000;
    localparam logic [31:0] IR_SHR  = 32'h2000_0000;
    localparam logic [31:0] IR_SHL  = 32'h2800_0000;
    localparam logic [31:0] IR_MUL  = 32'h7800_0000;
    localparam logic [31:0] IR_DIV  = 32'h8000_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_UNDF = 32'h3000_0000;

    typedef struct packed {
        logic [95:0] tag;
        logic [31:0] ir;
        logic        strt;
        logic        stop;
        logic [18:0] strobes;
        logic [3:0]  alu;
        logic        run;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;
    logic watch_hilo;
    logic hilo_seen;

    always @(negedge Clock) begin
        if (watch_hilo && (bus.HIin || bus.LOin)) hilo_seen = 1'b1;
    end

    function automatic logic [18:0] sample_strobes();
        return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zloout, bus.Zhiout,
                bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout};
    endfunction

    function automatic void add_cycle(input logic [95:0] tag, input logic [31:0] ir,
                                      input logic strt, input logic stop,
                                      input logic [18:0] strobes, input logic [3:0] alu,
                                      input logic run);
        vec_t v;
        v.tag = tag; v.ir = ir; v.strt = strt; v.stop = stop;
        v.strobes = strobes; v.alu = alu; v.run = run;
        vecs.push_back(v);
    endfunction

    function automatic void add_alu_instr(input logic [31:0] ir, input logic [3:0] alu);
        add_cycle("alu_T1", ir, 0, 0, E_T1,  4'b0000, 1);
        add_cycle("alu_T2", ir, 0, 0, E_T2,  4'b0000, 1);
        add_cycle("alu_T3", ir, 0, 0, E_T3,  4'b0000, 1);
        add_cycle("alu_T4", ir, 0, 0, E_T4,  alu,     1);
        add_cycle("alu_T5", ir, 0, 0, E_T5A, 4'b0000, 1);
        add_cycle("alu_T0", ir, 0, 0, E_T0,  4'b0000, 1);
    endfunction

    function automatic void add_muldiv_instr(input logic [31:0] ir, input logic [3:0] alu);
        add_cycle("md_T1", ir, 0, 0, E_T1,  4'b0000, 1);
        add_cycle("md_T2", ir, 0, 0, E_T2,  4'b0000, 1);
        add_cycle("md_T3", ir, 0, 0, E_T3,  4'b0000, 1);
        add_cycle("md_T4", ir, 0, 0, E_T4,  alu,     1);
        add_cycle("md_T5", ir, 0, 0, E_T5M, 4'b0000, 1);
        add_cycle("md_T6", ir, 0, 0, E_T6,  4'b0000, 1);
        add_cycle("md_T0", ir, 0, 0, E_T0,  4'b0000, 1);
    endfunction

    function automatic void add_nop_instr(input logic [31:0] ir);
        add_cycle("nop_T1", ir, 0, 0, E_T1,   4'b0000, 1);
        add_cycle("nop_T2", ir, 0, 0, E_T2,   4'b0000, 1);
        add_cycle("nop_T3", ir, 0, 0, E_NONE, 4'b0000, 1);
        add_cycle("nop_T0", ir, 0, 0, E_T0,   4'b0000, 1);
    endfunction

    function automatic void add_halt_entry();
        add_cycle("hlt_T1", IR_HALT, 0, 0, E_T1,   4'b0000, 1);
        add_cycle("hlt_T2", IR_HALT, 0, 0, E_T2,   4'b0000, 1);
        add_cycle("hlt_T3", IR_HALT, 0, 0, E_NONE, 4'b0000, 1);
        add_cycle("hlt_H",  IR_HALT, 0, 0, E_NONE, 4'b0000, 0);
    endfunction

    task automatic applyStimulus(input logic [31:0] ir, input logic strt, input logic stop);
        bus.IR   = ir;
        bus.Strt = strt;
        bus.Stop = stop;
    endtask

    task automatic checkOutput(input logic [95:0] tag, input int idx,
                               input logic [18:0] exp_strb, input logic [3:0] exp_alu,
                               input logic exp_run);
        logic [18:0] got_strb;
        got_strb = sample_strobes();
        n_checks++;
        if (got_strb !== exp_strb || bus.ALUControl !== exp_alu || bus.Run !== exp_run) begin
            n_fail++;
            $display("[TB] FAIL %0s #%0d: got strobes=%b alu=%b run=%b, expected strobes=%b alu=%b run=%b",
                     tag, idx, got_strb, bus.ALUControl, bus.Run, exp_strb, exp_alu, exp_run);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        watch_hilo  = 1'b0;
        hilo_seen   = 1'b0;
        GlobalReset = 1'b0;
        applyStimulus(IR_ADD, 0, 0);

        #2;
        checkOutput("reset_noclk", 0, E_NONE, 4'b0000, 1);
        @(posedge Clock); @(posedge Clock); #1;
        checkOutput("reset_clk", 0, E_NONE, 4'b0000, 1);
        @(negedge Clock);
        GlobalReset = 1'b1;

        // ADD from reset release: T0 on edge 1, back in T0 on edge 7
        add_cycle("add_T0", IR_ADD, 0, 0, E_T0, 4'b0000, 1);
        add_alu_instr(IR_ADD, 4'b0001);
        add_muldiv_instr(IR_MUL, 4'b0111);
        add_alu_instr(IR_SUB, 4'b0010);
        add_alu_instr(IR_AND, 4'b0011);
        add_alu_instr(IR_OR,  4'b0100);
        add_alu_instr(IR_SHR, 4'b0101);
        add_alu_instr(IR_SHL, 4'b0110);
        add_muldiv_instr(IR_DIV, 4'b1000);
        add_nop_instr(IR_NOP);
        add_nop_instr(IR_UNDF);

        // Strt outside HALT must not disturb the sequence
        add_cycle("strt_T1", IR_NOP, 1, 0, E_T1,   4'b0000, 1);
        add_cycle("strt_T2", IR_NOP, 1, 0, E_T2,   4'b0000, 1);
        add_cycle("strt_T3", IR_NOP, 1, 0, E_NONE, 4'b0000, 1);
        add_cycle("strt_T0", IR_NOP, 0, 0, E_T0,   4'b0000, 1);

        // HALT opcode, stay in HALT, one-cycle Strt resumes
        add_halt_entry();
        add_cycle("hlt_stay", IR_HALT, 0, 0, E_NONE, 4'b0000, 0);
        add_cycle("hlt_strt", IR_ADD,  1, 0, E_T0,   4'b0000, 1);

        // Stop pulsed in T1 of ADD: ADD completes with Rin, then HALT
        add_cycle("stp_T1",   IR_ADD, 0, 0, E_T1,   4'b0000, 1);
        add_cycle("stp_T2",   IR_ADD, 0, 1, E_T2,   4'b0000, 1);
        add_cycle("stp_T3",   IR_ADD, 0, 0, E_T3,   4'b0000, 1);
        add_cycle("stp_T4",   IR_ADD, 0, 0, E_T4,   4'b0001, 1);
        add_cycle("stp_T5",   IR_ADD, 0, 0, E_T5A,  4'b0000, 1);
        add_cycle("stp_H",    IR_ADD, 0, 0, E_NONE, 4'b0000, 0);
        add_cycle("stp_stay", IR_ADD, 0, 0, E_NONE, 4'b0000, 0);
        add_cycle("stp_strt", IR_ADD, 1, 0, E_T0,   4'b0000, 1);

        // Strt and Stop together in HALT: resume, but halt after the next instruction
        add_halt_entry();
        add_cycle("both_T0", IR_ADD, 1, 1, E_T0,   4'b0000, 1);
        add_cycle("both_T1", IR_ADD, 0, 0, E_T1,   4'b0000, 1);
        add_cycle("both_T2", IR_ADD, 0, 0, E_T2,   4'b0000, 1);
        add_cycle("both_T3", IR_ADD, 0, 0, E_T3,   4'b0000, 1);
        add_cycle("both_T4", IR_ADD, 0, 0, E_T4,   4'b0001, 1);
        add_cycle("both_T5", IR_ADD, 0, 0, E_T5A,  4'b0000, 1);
        add_cycle("both_H",  IR_ADD, 0, 0, E_NONE, 4'b0000, 0);
        add_cycle("both_rs", IR_ADD, 1, 0, E_T0,   4'b0000, 1);
        // Stop flag was cleared on HALT entry, so this ADD returns to T0
        add_alu_instr(IR_ADD, 4'b0001);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ir, vecs[i].strt, vecs[i].stop);
            @(posedge Clock); #1;
            checkOutput(vecs[i].tag, i, vecs[i].strobes, vecs[i].alu, vecs[i].run);
        end

        // Reset in the middle of DIV T4 abandons the instruction
        applyStimulus(IR_DIV, 0, 0);
        @(posedge Clock); #1; checkOutput("div_T1", 0, E_T1, 4'b0000, 1);
        @(posedge Clock); #1; checkOutput("div_T2", 0, E_T2, 4'b0000, 1);
        @(posedge Clock); #1; checkOutput("div_T3", 0, E_T3, 4'b0000, 1);
        @(posedge Clock); #1; checkOutput("div_T4", 0, E_T4, 4'b1000, 1);
        watch_hilo = 1'b1;
        #2;
        GlobalReset = 1'b0;
        #1;
        checkOutput("rst_async", 0, E_NONE, 4'b0000, 1);
        if (bus.HIin || bus.LOin) hilo_seen = 1'b1;
        @(posedge Clock); #1;
        checkOutput("rst_hold", 0, E_NONE, 4'b0000, 1);
        applyStimulus(IR_NOP, 0, 0);
        @(negedge Clock);
        GlobalReset = 1'b1;
        @(posedge Clock); #1; checkOutput("post_T0", 0, E_T0,   4'b0000, 1);
        @(posedge Clock); #1; checkOutput("post_T1", 0, E_T1,   4'b0000, 1);
        @(posedge Clock); #1; checkOutput("post_T2", 0, E_T2,   4'b0000, 1);
        @(posedge Clock); #1; checkOutput("post_T3", 0, E_NONE, 4'b0000, 1);
        @(posedge Clock); #1; checkOutput("post_T0b", 0, E_T0,  4'b0000, 1);
        watch_hilo = 1'b0;

        n_checks++;
        if (hilo_seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abandoned_div_hilo: got HIin/LOin seen=%b, expected 0", hilo_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
